// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the calculator word memory controller.
package mem_ctrl_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  function automatic int unsigned byte_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with byte-enable writes and a registered read port.
module mem_array
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  we_i,
  input  logic                                  re_i,
  input  logic [ADDR_WIDTH-1:0]                 addr_i,
  input  logic [DATA_WIDTH-1:0]                 wdata_i,
  input  logic [byte_count(DATA_WIDTH)-1:0]     be_i,
  output logic [DATA_WIDTH-1:0]                 rdata_o
);

  localparam int unsigned NumBytes = byte_count(DATA_WIDTH);
  localparam int unsigned Depth    = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Storage is deliberately unreset; the controller's sweep zeroes it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[addr_i];
  end

  // Only the read register is reset so the output reads 0 until the first read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Word memory controller: valid/ready requests, byte-enable writes, READ_LAT-cycle
// reads with an Rvalid strobe, and a clear sweep after reset or on Clr.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Valid,
  output logic                              Ready,
  input  logic                              R_W,
  input  logic [ADDR_WIDTH-1:0]             Addr,
  input  logic [DATA_WIDTH-1:0]             Din,
  input  logic [byte_count(DATA_WIDTH)-1:0] Be,
  input  logic                              Clr,
  output logic [DATA_WIDTH-1:0]             Dout,
  output logic                              Rvalid,
  output logic                              Busy
);

  localparam int unsigned NumBytes = byte_count(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                  state_d, state_q;
  logic [ADDR_WIDTH-1:0]   cnt_d, cnt_q;
  logic                    accept, arr_we, arr_re;
  logic [ADDR_WIDTH-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0]   arr_wdata, arr_rdata;
  logic [NumBytes-1:0]     arr_be;
  logic                    rvalid1_d, rvalid1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Ready   = 1'b0;
    Busy    = 1'b0;
    unique case (state_q)
      StClear: begin
        Busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) state_d = StIdle;
      end
      StIdle: begin
        // Clr blocks acceptance in the same cycle it starts the sweep.
        Ready = !Clr;
        if (Clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accept    = Valid && Ready;
  assign arr_we    = Busy || (accept && (R_W == MEM_WRITE));
  assign arr_re    = accept && (R_W == MEM_READ);
  assign arr_addr  = Busy ? cnt_q : Addr;
  assign arr_wdata = Busy ? '0 : Din;
  assign arr_be    = Busy ? '1 : Be;
  assign rvalid1_d = arr_re;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_array (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rvalid1_q <= 1'b0;
    else       rvalid1_q <= rvalid1_d;
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout2_d, dout2_q;
    logic                  rvalid2_d, rvalid2_q;

    always_comb begin
      rvalid2_d = rvalid1_q;
      dout2_d   = dout2_q;
      if (rvalid1_q) dout2_d = arr_rdata;
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        dout2_q   <= '0;
        rvalid2_q <= 1'b0;
      end else begin
        dout2_q   <= dout2_d;
        rvalid2_q <= rvalid2_d;
      end
    end

    assign Dout   = dout2_q;
    assign Rvalid = rvalid2_q;
  end else begin : g_lat1
    assign Dout   = arr_rdata;
    assign Rvalid = rvalid1_q;
  end

endmodule
